// File: rtl/rename_reg_file.sv
// rename_reg_file: rename map, free list, ready bits, physical data array and one-cycle branch checkpoints.
// Define RENAME_RF_BYPASS_EN to forward a same-cycle writeback onto the read ports.
module rename_reg_file #(
    parameter int DATA_WIDTH  = 32,
    parameter int ARCH_REGS   = 32,
    parameter int PHYS_REGS   = 64,
    parameter int CHECKPOINTS = 4,
    localparam int AW = $clog2(ARCH_REGS),
    localparam int PW = $clog2(PHYS_REGS),
    localparam int CW = $clog2(CHECKPOINTS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rn_valid,
    input  logic [AW-1:0]         rn_rs,
    input  logic [AW-1:0]         rn_rt,
    input  logic [AW-1:0]         rn_rw,
    input  logic                  rn_uses_rw,
    output logic                  rn_ready,
    output logic [PW-1:0]         rn_ps,
    output logic [PW-1:0]         rn_pt,
    output logic [PW-1:0]         rn_pw,
    output logic [PW-1:0]         rn_old_pw,
    input  logic                  wb_valid,
    input  logic [PW-1:0]         wb_preg,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [PW-1:0]         rd_a_addr,
    input  logic [PW-1:0]         rd_b_addr,
    output logic [DATA_WIDTH-1:0] rd_a_data,
    output logic [DATA_WIDTH-1:0] rd_b_data,
    output logic                  rd_a_rdy,
    output logic                  rd_b_rdy,
    input  logic                  cm_valid,
    input  logic [PW-1:0]         cm_preg,
    input  logic                  ckpt_take,
    output logic [CW-1:0]         ckpt_id,
    output logic                  ckpt_full,
    input  logic                  ckpt_release,
    input  logic                  rs_valid,
    input  logic [CW-1:0]         rs_id,
    output logic [PW:0]           free_count
);
    logic [PW-1:0]         map_q [ARCH_REGS];
    logic [PW-1:0]         map_d [ARCH_REGS];
    logic [PHYS_REGS-1:0]  free_q, free_d, rdy_q, rdy_d;
    logic [DATA_WIDTH-1:0] data_q [PHYS_REGS];
    logic [DATA_WIDTH-1:0] data_d [PHYS_REGS];
    logic [PW-1:0]         snap_q [CHECKPOINTS][ARCH_REGS];
    logic [PW-1:0]         snap_d [CHECKPOINTS][ARCH_REGS];
    logic [PHYS_REGS-1:0]  amask_q [CHECKPOINTS];
    logic [PHYS_REGS-1:0]  amask_d [CHECKPOINTS];
    logic [CW-1:0]         head_q, head_d, tail_q, tail_d;
    logic [CW:0]           cnt_q, cnt_d;
    logic [CHECKPOINTS-1:0] ck_live;
    logic [PW-1:0]         alloc_idx;
    logic                  need_alloc, do_alloc, do_take, do_rel, rs_live, byp_a, byp_b;

    // Lowest free index wins because the scan runs downward and keeps overwriting.
    always_comb begin
        alloc_idx  = '0;
        free_count = '0;
        for (int i = PHYS_REGS - 1; i >= 0; i--) begin
            if (free_q[i]) alloc_idx = PW'(i);
            free_count = free_count + (PW+1)'(free_q[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < CHECKPOINTS; i++)
            ck_live[i] = {1'b0, CW'(i) - head_q} < cnt_q;
    end

    always_comb begin
        need_alloc = rn_uses_rw && rn_rw != '0;
        rn_ready   = !rs_valid && (free_count != '0 || !need_alloc);
        do_alloc   = rn_valid && rn_ready && need_alloc;
        ckpt_full  = cnt_q == (CW+1)'(CHECKPOINTS);
        do_take    = ckpt_take && !ckpt_full && !rs_valid;
        do_rel     = ckpt_release && cnt_q != '0 && !rs_valid;
        rs_live    = rs_valid && ck_live[rs_id];
        rn_ps      = map_q[rn_rs];
        rn_pt      = map_q[rn_rt];
        rn_old_pw  = map_q[rn_rw];
        rn_pw      = need_alloc ? alloc_idx : '0;
        ckpt_id    = tail_q;
    end

`ifdef RENAME_RF_BYPASS_EN
    always_comb begin
        byp_a = wb_valid && wb_preg == rd_a_addr && rd_a_addr != '0;
        byp_b = wb_valid && wb_preg == rd_b_addr && rd_b_addr != '0;
    end
`else
    always_comb begin
        byp_a = 1'b0;
        byp_b = 1'b0;
    end
`endif

    always_comb begin
        rd_a_data = byp_a ? wb_data : data_q[rd_a_addr];
        rd_b_data = byp_b ? wb_data : data_q[rd_b_addr];
        rd_a_rdy  = byp_a || rdy_q[rd_a_addr];
        rd_b_rdy  = byp_b || rdy_q[rd_b_addr];
    end

    always_comb begin
        map_d   = map_q;
        free_d  = free_q;
        rdy_d   = rdy_q;
        data_d  = data_q;
        snap_d  = snap_q;
        amask_d = amask_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q + (CW+1)'(do_take) - (CW+1)'(do_rel);
        if (do_alloc) begin
            map_d[rn_rw]      = alloc_idx;
            free_d[alloc_idx] = 1'b0;
            rdy_d[alloc_idx]  = 1'b0;
            for (int c = 0; c < CHECKPOINTS; c++)
                if (ck_live[c]) amask_d[c][alloc_idx] = 1'b1;
        end
        // The new snapshot already contains this cycle's rename, so its mask starts empty.
        if (do_take) begin
            snap_d[tail_q]  = map_d;
            amask_d[tail_q] = '0;
            tail_d          = tail_q + 1'b1;
        end
        if (do_rel) head_d = head_q + 1'b1;
        if (rs_live) begin
            map_d  = snap_q[rs_id];
            free_d = free_d | amask_q[rs_id];
            tail_d = rs_id;
            cnt_d  = {1'b0, rs_id - head_q};
        end
        if (wb_valid && wb_preg != '0) begin
            data_d[wb_preg] = wb_data;
            rdy_d[wb_preg]  = 1'b1;
        end
        if (cm_valid && cm_preg != '0) free_d[cm_preg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= PW'(i);
            for (int i = 0; i < PHYS_REGS; i++) data_q[i] <= '0;
            free_q <= {{(PHYS_REGS-ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
            rdy_q  <= {{(PHYS_REGS-ARCH_REGS){1'b0}}, {ARCH_REGS{1'b1}}};
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            map_q  <= map_d;
            data_q <= data_d;
            free_q <= free_d;
            rdy_q  <= rdy_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Slot contents are only read while live, so they need no reset.
    always_ff @(posedge clk) begin
        snap_q  <= snap_d;
        amask_q <= amask_d;
    end
endmodule

// File: tb/tb_rename_reg_file.sv
// tb_rename_reg_file: directed and random checks of rename_reg_file against a queue-based reference model.
module tb_rename_reg_file;
    localparam int AR = 32, PR = 64, CK = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic rn_valid, rn_uses_rw, rn_ready;
    logic [4:0] rn_rs, rn_rt, rn_rw;
    logic [5:0] rn_ps, rn_pt, rn_pw, rn_old_pw;
    logic wb_valid, cm_valid, ckpt_take, ckpt_release, ckpt_full, rs_valid;
    logic [5:0] wb_preg, cm_preg, rd_a_addr, rd_b_addr;
    logic [31:0] wb_data, rd_a_data, rd_b_data;
    logic rd_a_rdy, rd_b_rdy;
    logic [1:0] ckpt_id, rs_id;
    logic [6:0] free_count;
    int total = 0, bad = 0;

    int m_map[AR];
    bit m_free[PR];
    bit m_rdy[PR];
    logic [31:0] m_data[PR];
    int ck_q[$];
    int ck_snap[CK][AR];
    bit ck_mask[CK][PR];
    int m_tail;

    always #5 clk = ~clk;

    rename_reg_file dut (
        .clk(clk), .reset(reset),
        .rn_valid(rn_valid), .rn_rs(rn_rs), .rn_rt(rn_rt), .rn_rw(rn_rw), .rn_uses_rw(rn_uses_rw),
        .rn_ready(rn_ready), .rn_ps(rn_ps), .rn_pt(rn_pt), .rn_pw(rn_pw), .rn_old_pw(rn_old_pw),
        .wb_valid(wb_valid), .wb_preg(wb_preg), .wb_data(wb_data),
        .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .rd_a_rdy(rd_a_rdy), .rd_b_rdy(rd_b_rdy),
        .cm_valid(cm_valid), .cm_preg(cm_preg),
        .ckpt_take(ckpt_take), .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
        .rs_valid(rs_valid), .rs_id(rs_id), .free_count(free_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < AR; i++) m_map[i] = i;
        for (int i = 0; i < PR; i++) begin
            m_free[i] = i >= AR;
            m_rdy[i]  = i < AR;
            m_data[i] = 32'h0;
        end
        ck_q.delete();
        m_tail = 0;
    endfunction

    function automatic int m_fc();
        int n = 0;
        for (int i = 0; i < PR; i++) n += int'(m_free[i]);
        return n;
    endfunction

    function automatic int m_low();
        for (int i = 0; i < PR; i++) if (m_free[i]) return i;
        return 0;
    endfunction

    function automatic logic [32:0] m_read(input logic [5:0] a);
        if (a == 0) return {1'b1, 32'h0};
`ifdef RENAME_RF_BYPASS_EN
        if (wb_valid && wb_preg == a) return {1'b1, wb_data};
`endif
        return {m_rdy[a], m_data[a]};
    endfunction

    task automatic idle();
        {rn_valid, rn_uses_rw, wb_valid, cm_valid, ckpt_take, ckpt_release, rs_valid, reset} = '0;
        {rn_rs, rn_rt, rn_rw} = '0;
        {wb_preg, cm_preg, rd_a_addr, rd_b_addr} = '0;
        wb_data = '0;
        rs_id = '0;
    endtask

    task automatic settle();
        bit need;
        int fc;
        logic [32:0] ra, rb;
        #1;
        need = rn_uses_rw && rn_rw != 0;
        fc = m_fc();
        ra = m_read(rd_a_addr);
        rb = m_read(rd_b_addr);
        chk("rn_ready", rn_ready, !rs_valid && (fc > 0 || !need));
        if (!need) chk("rn_pw_none", rn_pw, 0);
        else if (fc > 0) chk("rn_pw", rn_pw, m_low());
        chk("rn_ps", rn_ps, m_map[rn_rs]);
        chk("rn_pt", rn_pt, m_map[rn_rt]);
        chk("rn_old_pw", rn_old_pw, m_map[rn_rw]);
        chk("free_count", free_count, fc);
        chk("ckpt_full", ckpt_full, ck_q.size() == CK);
        chk("ckpt_id", ckpt_id, m_tail);
        chk("rd_a_data", rd_a_data, ra[31:0]);
        chk("rd_a_rdy", rd_a_rdy, ra[32]);
        chk("rd_b_data", rd_b_data, rb[31:0]);
        chk("rd_b_rdy", rd_b_rdy, rb[32]);
    endtask

    task automatic m_step();
        bit need, ok, take, rel;
        int low, pos;
        need = rn_uses_rw && rn_rw != 0;
        ok = !rs_valid && (m_fc() > 0 || !need);
        low = m_low();
        pos = -1;
        if (reset) begin
            m_reset();
            return;
        end
        foreach (ck_q[k]) if (ck_q[k] == int'(rs_id)) pos = k;
        if (rs_valid) begin
            if (pos >= 0) begin
                m_map = ck_snap[rs_id];
                for (int j = 0; j < PR; j++) if (ck_mask[rs_id][j]) m_free[j] = 1'b1;
                while (ck_q.size() > pos) void'(ck_q.pop_back());
                m_tail = rs_id;
            end
        end else begin
            take = ckpt_take && ck_q.size() < CK;
            rel = ckpt_release && ck_q.size() > 0;
            if (rn_valid && ok && need) begin
                m_map[rn_rw] = low;
                m_free[low] = 1'b0;
                m_rdy[low] = 1'b0;
                foreach (ck_q[k]) ck_mask[ck_q[k]][low] = 1'b1;
            end
            if (take) begin
                ck_snap[m_tail] = m_map;
                for (int j = 0; j < PR; j++) ck_mask[m_tail][j] = 1'b0;
                ck_q.push_back(m_tail);
                m_tail = (m_tail + 1) % CK;
            end
            if (rel) void'(ck_q.pop_front());
        end
        if (wb_valid && wb_preg != 0) begin
            m_data[wb_preg] = wb_data;
            m_rdy[wb_preg] = 1'b1;
        end
        if (cm_valid && cm_preg != 0) m_free[cm_preg] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
        idle();
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic rename(input logic [4:0] rw);
        rn_valid = 1'b1;
        rn_uses_rw = 1'b1;
        rn_rw = rw;
    endtask

    initial begin
        int fc0;
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        idle();
        settle();
        chk("rst_free_count", free_count, 32);
        chk("rst_ckpt_full", ckpt_full, 0);
        chk("rst_ckpt_id", ckpt_id, 0);
        chk("rst_rn_ready", rn_ready, 1);
        tick();

        rename(5);
        settle();
        chk("first_pw", rn_pw, 32);
        chk("first_old_pw", rn_old_pw, 5);
        tick();
        rn_rs = 5;
        settle();
        chk("ps_after_rename", rn_ps, 32);
        chk("fc_after_rename", free_count, 31);
        tick();

        for (int i = 0; i < 31; i++) begin
            rename(1);
            cyc();
        end
        rename(1);
        cm_valid = 1'b1;
        cm_preg = 6'd1;
        settle();
        chk("exhaust_fc", free_count, 0);
        chk("exhaust_ready", rn_ready, 0);
        tick();
        rename(1);
        settle();
        chk("refill_ready", rn_ready, 1);
        chk("refill_pw", rn_pw, 1);
        tick();
        reset = 1'b1;
        tick();

        ckpt_take = 1'b1;
        settle();
        chk("take_id", ckpt_id, 0);
        tick();
        rename(3);
        settle();
        chk("ck_pw3", rn_pw, 32);
        tick();
        rename(4);
        settle();
        chk("ck_pw4", rn_pw, 33);
        tick();
        rename(7);
        rs_valid = 1'b1;
        rs_id = 2'd0;
        settle();
        chk("restore_blocks_rename", rn_ready, 0);
        tick();
        rn_rs = 3;
        rn_rt = 4;
        settle();
        chk("restored_map3", rn_ps, 3);
        chk("restored_map4", rn_pt, 4);
        chk("restored_fc", free_count, 32);
        chk("restored_empty", ckpt_full, 0);
        tick();

        for (int i = 0; i < 4; i++) begin
            ckpt_take = 1'b1;
            cyc();
        end
        ckpt_take = 1'b1;
        settle();
        chk("ckpt_full_4", ckpt_full, 1);
        tick();
        ckpt_release = 1'b1;
        settle();
        chk("fifth_ignored", ckpt_full, 1);
        tick();
        settle();
        chk("released_not_full", ckpt_full, 0);
        tick();

        wb_valid = 1'b1;
        wb_preg = 6'd40;
        wb_data = 32'hDEADBEEF;
        rd_a_addr = 6'd40;
        settle();
`ifdef RENAME_RF_BYPASS_EN
        chk("bypass_data", rd_a_data, 32'hDEADBEEF);
        chk("bypass_rdy", rd_a_rdy, 1);
`else
        chk("nobypass_data", rd_a_data, 0);
        chk("nobypass_rdy", rd_a_rdy, 0);
`endif
        tick();
        rd_a_addr = 6'd40;
        settle();
        chk("wb_data_next", rd_a_data, 32'hDEADBEEF);
        chk("wb_rdy_next", rd_a_rdy, 1);
        tick();

        rename(0);
        wb_valid = 1'b1;
        wb_preg = 6'd0;
        wb_data = 32'd7;
        rd_b_addr = 6'd0;
        settle();
        fc0 = free_count;
        chk("rw0_pw", rn_pw, 0);
        chk("rw0_ready", rn_ready, 1);
        chk("p0_data_same", rd_b_data, 0);
        chk("p0_rdy", rd_b_rdy, 1);
        tick();
        settle();
        chk("rw0_no_alloc", free_count, fc0);
        chk("p0_data_after", rd_b_data, 0);
        tick();

        for (int n = 0; n < 800; n++) begin
            rn_valid = $urandom_range(1, 0) == 1;
            rn_uses_rw = $urandom_range(4, 0) != 0;
            rn_rs = 5'($urandom);
            rn_rt = 5'($urandom);
            rn_rw = 5'($urandom);
            wb_valid = $urandom_range(1, 0) == 1;
            wb_preg = 6'($urandom);
            wb_data = $urandom;
            rd_a_addr = $urandom_range(3, 0) == 0 ? wb_preg : 6'($urandom);
            rd_b_addr = 6'($urandom);
            cm_valid = $urandom_range(2, 0) == 0;
            cm_preg = 6'($urandom);
            ckpt_take = $urandom_range(3, 0) == 0;
            ckpt_release = $urandom_range(5, 0) == 0;
            rs_valid = $urandom_range(15, 0) == 0;
            rs_id = 2'($urandom);
            reset = $urandom_range(299, 0) == 0;
            cyc();
        end

        reset = 1'b1;
        tick();
        ckpt_take = 1'b1;
        cyc();
        rename(3);
        cyc();
        wb_valid = 1'b1;
        wb_preg = 6'd40;
        wb_data = 32'd5;
        cyc();
        rs_valid = 1'b1;
        rs_id = 2'd0;
        reset = 1'b1;
        tick();
        rn_rs = 3;
        rd_a_addr = 6'd40;
        settle();
        chk("rst_mid_map", rn_ps, 3);
        chk("rst_mid_fc", free_count, 32);
        chk("rst_mid_full", ckpt_full, 0);
        chk("rst_mid_id", ckpt_id, 0);
        chk("rst_mid_data", rd_a_data, 0);
        chk("rst_mid_rdy", rd_a_rdy, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Parametrised successor to the core's rename/physical register file.
- Holds the architectural-to-physical map, the free list, per-register ready bits, and a physical data array with 2 read ports and 1 write port.
- Takes up to CHECKPOINTS branch checkpoints and restores them in one cycle. On restore, every register allocated since that checkpoint goes back on the free list.
- Sits between decode (rename request) and issue/writeback/commit.

Parameters:
DATA_WIDTH, 32, width of each physical register
ARCH_REGS, 32, number of architectural registers (power of 2)
PHYS_REGS, 64, number of physical registers (power of 2, > ARCH_REGS)
CHECKPOINTS, 4, depth of the checkpoint FIFO (power of 2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rn_valid  in  1  rename request
rn_rs, rn_rt  in  log2(ARCH_REGS)  source architectural registers
rn_rw  in  log2(ARCH_REGS)  destination architectural register
rn_uses_rw  in  1  destination present
rn_ready  out  1  rename accepted this cycle
rn_ps, rn_pt  out  log2(PHYS_REGS)  mapped sources (combinational, pre-update map)
rn_pw  out  log2(PHYS_REGS)  newly allocated destination
rn_old_pw  out  log2(PHYS_REGS)  previous mapping of rn_rw (freed at commit)
wb_valid  in  1  writeback
wb_preg  in  log2(PHYS_REGS)  writeback destination
wb_data  in  DATA_WIDTH  writeback data
rd_a_addr, rd_b_addr  in  log2(PHYS_REGS)  read addresses
rd_a_data, rd_b_data  out  DATA_WIDTH  asynchronous read data
rd_a_rdy, rd_b_rdy  out  1  ready bit of the addressed register
cm_valid  in  1  commit-free request
cm_preg  in  log2(PHYS_REGS)  register to free
ckpt_take  in  1  take a checkpoint
ckpt_id  out  log2(CHECKPOINTS)  id of the checkpoint taken this cycle
ckpt_full  out  1  no checkpoint slot free
ckpt_release  in  1  retire the oldest checkpoint (branch resolved correctly)
rs_valid  in  1  restore request (mispredict)
rs_id  in  log2(CHECKPOINTS)  checkpoint to restore
free_count  out  log2(PHYS_REGS)+1  number of free physical registers

Behaviour:
- Reset state:
  - map[i]=i.
  - Pregs 0..ARCH_REGS-1 allocated and ready; the rest are free and not ready.
  - Data array all zero.
  - Checkpoint FIFO empty.
  - free_count=PHYS_REGS-ARCH_REGS; ckpt_full=0; rn_ready=(free_count>0); ckpt_id=0.
- Arch reg 0 is pinned to preg 0.
  - rn_rw=0 or !rn_uses_rw: no allocation; rn_pw=0; rn_ready=!rs_valid.
  - Writes to preg 0 are dropped; preg 0 always reads 0 and is always ready.
- Allocation:
  - Lowest-index free preg, at most one per cycle, chosen from the registered free list.
  - When rn_valid&rn_ready&rn_uses_rw&rn_rw!=0: the map updates, the allocated preg leaves the free list and its ready bit clears, all on the next edge.
  - rn_ready=(free_count>0)&!rs_valid. free_count=0 -> rn_ready=0 and no state change.
- Source mapping: rn_ps/rn_pt read the pre-update map. Same-cycle rn_rs==rn_rw returns the old mapping.
- Writeback: data and ready bit are written at the edge.
- Commit free: cm_preg returns to the free list at the edge.
  - A preg freed in cycle N is allocatable no earlier than cycle N+1.
  - cm_preg=0 is ignored.
- Checkpoints: circular FIFO with head/tail/count.
  - Accepted when ckpt_take&!ckpt_full&!rs_valid. The snapshot stores the map including the same-cycle rename, and clears that slot's alloc mask; ckpt_id=tail.
  - Every allocation sets its preg bit in the alloc mask of every live checkpoint.
  - ckpt_release pops head; ignored when the FIFO is empty.
- Restore (rs_valid, rs_id live):
  - map <= snap[rs_id].
  - free |= alloc_mask[rs_id]; those pregs' ready bits stay as they are.
  - tail <= rs_id; count <= distance from head to rs_id, so rs_id and all younger checkpoints are discarded.
  - Same-cycle rename, ckpt_take and ckpt_release are ignored. Same-cycle wb and cm still apply.
  - rs_id not live -> no effect.
- reset mid-operation overrides everything; state returns to reset values on the next edge.
- Read ports are asynchronous. Same-cycle wb to the read address: see feature.

Optional Feature:
RENAME_RF_BYPASS_EN:
- Defined: when wb_valid and wb_preg==rd_x_addr (non-zero) in the same cycle, rd_x_data=wb_data and rd_x_rdy=1.
- Undefined: the read returns the old array value and ready bit; the new value is visible from the next cycle.

Test Plan:
- reset; rename rw=5 -> rn_pw=32, rn_old_pw=5, free_count 32->31; next cycle rn_rs=5 -> rn_ps=32.
- 32 back-to-back renames of rw=1 -> free_count=0, rn_ready=0. Then cm_preg=1 -> rn_ready=1 next cycle, next allocation=1.
- ckpt_take (ckpt_id=0), rename rw=3 (preg 32), rw=4 (preg 33), then rs_valid id=0 -> map[3]=3, map[4]=4, free_count back to 32, count=0.
- 4 ckpt_take -> ckpt_full=1; 5th ignored; ckpt_release -> ckpt_full=0.
- wb preg 40 data 0xDEADBEEF while reading 40 -> RENAME_RF_BYPASS_EN: 0xDEADBEEF same cycle, rdy=1; otherwise old value, then 0xDEADBEEF next cycle.
- rename rw=0 and wb preg 0 data 7 -> no allocation, read of preg 0 returns 0; reset asserted during restore -> full reset state.
